// File: rtl/apu_frame_sequencer.sv
// Frame sequencer: divides the system clock into APU frame steps and issues quarter/half-frame pulses.
// Optional frame IRQ (flag, inhibit bit, irq_ack) is built only when APU_FRAME_IRQ_EN is defined.
module apu_frame_sequencer #(
   parameter int STEP_DIV = 7457
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   input  logic       irq_ack,
   output logic       quarter_tick,
   output logic       half_tick,
   output logic       irq,
   output logic [2:0] step,
   output logic       mode
);

   localparam int DIV_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

   logic [DIV_W-1:0] div_q, div_d;
   logic [2:0]       step_q, step_d;
   logic             mode_q, mode_d;
   logic             quarter_q, quarter_d;
   logic             half_q, half_d;
   logic             step_evt;

   // A write restarts the schedule and wins over a coincident terminal count.
   always_comb begin
      div_d     = div_q + DIV_W'(1);
      step_d    = step_q;
      mode_d    = mode_q;
      quarter_d = 1'b0;
      half_d    = 1'b0;
      step_evt  = 1'b0;
      if (wr_en) begin
         div_d     = '0;
         step_d    = 3'd0;
         mode_d    = wr_data[7];
         quarter_d = wr_data[7];
         half_d    = wr_data[7];
      end else if (div_q == DIV_LAST) begin
         div_d    = '0;
         step_evt = 1'b1;
         if (mode_q) begin
            quarter_d = (step_q != 3'd3);
            half_d    = (step_q == 3'd1) || (step_q == 3'd4);
            step_d    = (step_q >= 3'd4) ? 3'd0 : step_q + 3'd1;
         end else begin
            quarter_d = 1'b1;
            half_d    = (step_q == 3'd1) || (step_q == 3'd3);
            step_d    = (step_q >= 3'd3) ? 3'd0 : step_q + 3'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q     <= '0;
         step_q    <= 3'd0;
         mode_q    <= 1'b0;
         quarter_q <= 1'b0;
         half_q    <= 1'b0;
      end else begin
         div_q     <= div_d;
         step_q    <= step_d;
         mode_q    <= mode_d;
         quarter_q <= quarter_d;
         half_q    <= half_d;
      end
   end

`ifdef APU_FRAME_IRQ_EN
   logic inhibit_q, inhibit_d;
   logic irq_q, irq_d;
   logic unused_data;

   // Priority, lowest first so later assignments win: ack clear, step-3 set, inhibiting write.
   always_comb begin
      inhibit_d = inhibit_q;
      irq_d     = irq_q;
      if (irq_ack) irq_d = 1'b0;
      if (step_evt && !mode_q && (step_q == 3'd3) && !inhibit_q) irq_d = 1'b1;
      if (wr_en) begin
         inhibit_d = wr_data[6];
         if (wr_data[6]) irq_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inhibit_q <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         inhibit_q <= inhibit_d;
         irq_q     <= irq_d;
      end
   end

   assign unused_data = ^wr_data[5:0];
   assign irq         = irq_q;
`else
   logic unused_inputs;

   assign unused_inputs = ^{wr_data[6:0], irq_ack, step_evt};
   assign irq           = 1'b0;
`endif

   assign quarter_tick = quarter_q;
   assign half_tick    = half_q;
   assign step         = step_q;
   assign mode         = mode_q;

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Self-checking bench for apu_frame_sequencer with STEP_DIV=4; expectations come from a
// cycle-count-based reference model and are queued per edge, then compared after the edge.
module tb_apu_frame_sequencer;

   localparam int STEP_DIV = 4;
`ifdef APU_FRAME_IRQ_EN
   localparam bit IRQ_EN = 1'b1;
`else
   localparam bit IRQ_EN = 1'b0;
`endif

   logic       clk;
   logic       rst;
   logic       wrEn;
   logic [7:0] wrData;
   logic       irqAck;
   logic       quarterTick;
   logic       halfTick;
   logic       irqOut;
   logic [2:0] stepOut;
   logic       modeOut;

   apu_frame_sequencer #(.STEP_DIV(STEP_DIV)) dut (
      .clk          (clk),
      .rst          (rst),
      .wr_en        (wrEn),
      .wr_data      (wrData),
      .irq_ack      (irqAck),
      .quarter_tick (quarterTick),
      .half_tick    (halfTick),
      .irq          (irqOut),
      .step         (stepOut),
      .mode         (modeOut)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       quarter;
      logic       half;
      logic       irq;
      logic [2:0] step;
      logic       mode;
   } ExpT;

   ExpT scoreboard[$];
   int  nChecks = 0;
   int  nBad    = 0;

   // Reference model state: edges since the last reset/write sync point.
   bit mMode;
   bit mInh;
   bit mIrq;
   int mSince;

   // Single comparison point; every check is counted here.
   task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
      nChecks++;
      if (got !== exp) begin
         nBad++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic resetModel();
      mMode  = 1'b0;
      mInh   = 1'b0;
      mIrq   = 1'b0;
      mSince = 0;
      scoreboard.delete();
   endtask

   // Predicts outputs after one rising edge from the elapsed-cycle count, independent of any divider.
   task automatic modelEdge(input bit we, input logic [7:0] wd, input bit ack, output ExpT e);
      int period;
      int s;
      e.quarter = 1'b0;
      e.half    = 1'b0;
      if (we) begin
         mMode     = wd[7];
         mInh      = IRQ_EN && wd[6];
         mSince    = 0;
         e.quarter = wd[7];
         e.half    = wd[7];
         if (IRQ_EN && wd[6]) mIrq = 1'b0;
         else if (IRQ_EN && ack) mIrq = 1'b0;
      end else begin
         mSince++;
         period = mMode ? 5 : 4;
         if ((mSince % STEP_DIV) == 0) begin
            s = ((mSince / STEP_DIV) - 1) % period;
            if (mMode) begin
               e.quarter = (s != 3);
               e.half    = (s == 1) || (s == 4);
            end else begin
               e.quarter = 1'b1;
               e.half    = (s == 1) || (s == 3);
            end
            if (IRQ_EN && !mMode && (s == 3) && !mInh) mIrq = 1'b1;
            else if (IRQ_EN && ack) mIrq = 1'b0;
         end else if (IRQ_EN && ack) begin
            mIrq = 1'b0;
         end
      end
      e.irq  = mIrq;
      e.mode = mMode;
      e.step = 3'((mSince / STEP_DIV) % (mMode ? 5 : 4));
   endtask

   // Drives one cycle of inputs, queues the prediction, and checks the DUT just after the edge.
   task automatic applyStimulus(input bit we, input logic [7:0] wd, input bit ack, input string tag);
      ExpT e;
      ExpT want;
      wrEn   = we;
      wrData = wd;
      irqAck = ack;
      modelEdge(we, wd, ack, e);
      scoreboard.push_back(e);
      @(posedge clk);
      #1;
      if (scoreboard.size() == 0) begin
         checkOutput({tag, ".sb_empty"}, 8'd0, 8'd1);
      end else begin
         want = scoreboard.pop_front();
         checkOutput({tag, ".quarter"}, {7'd0, quarterTick}, {7'd0, want.quarter});
         checkOutput({tag, ".half"},    {7'd0, halfTick},    {7'd0, want.half});
         checkOutput({tag, ".irq"},     {7'd0, irqOut},      {7'd0, want.irq});
         checkOutput({tag, ".step"},    {5'd0, stepOut},     {5'd0, want.step});
         checkOutput({tag, ".mode"},    {7'd0, modeOut},     {7'd0, want.mode});
      end
      wrEn   = 1'b0;
      wrData = 8'h00;
      irqAck = 1'b0;
   endtask

   task automatic runIdle(input int n, input string tag);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0, tag);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, ".quarter"}, {7'd0, quarterTick}, 8'd0);
      checkOutput({tag, ".half"},    {7'd0, halfTick},    8'd0);
      checkOutput({tag, ".irq"},     {7'd0, irqOut},      8'd0);
      checkOutput({tag, ".step"},    {5'd0, stepOut},     8'd0);
      checkOutput({tag, ".mode"},    {7'd0, modeOut},     8'd0);
   endtask

   // Directed scenarios run back to back; the model tracks every edge after reset release.
   initial begin
      rst    = 1'b1;
      wrEn   = 1'b0;
      wrData = 8'h00;
      irqAck = 1'b0;
      resetModel();
      #12;
      checkAllZero("reset");
      @(negedge clk);
      rst = 1'b0;

      runIdle(16, "seq4");
      checkOutput("seq4.step_end", {5'd0, stepOut}, 8'd0);
      checkOutput("seq4.half_end", {7'd0, halfTick}, 8'd1);
      checkOutput("seq4.irq_end", {7'd0, irqOut}, {7'd0, IRQ_EN});

      // Reset lands while the step-3 half pulse (and irq) is high, away from any edge.
      #1;
      rst = 1'b1;
      #1;
      checkAllZero("arst");
      @(negedge clk);
      rst = 1'b0;
      resetModel();
      runIdle(16, "arst_seq");
      checkOutput("arst_seq.irq_end", {7'd0, irqOut}, {7'd0, IRQ_EN});

      applyStimulus(1'b0, 8'h00, 1'b1, "ack");
      checkOutput("ack.irq_clear", {7'd0, irqOut}, 8'd0);

      applyStimulus(1'b1, 8'h40, 1'b0, "wr40");
      runIdle(16, "inhibit");
      checkOutput("inhibit.irq_end", {7'd0, irqOut}, 8'd0);

      applyStimulus(1'b1, 8'h00, 1'b0, "wr00");
      runIdle(15, "pre_set");
      applyStimulus(1'b0, 8'h00, 1'b1, "ack_vs_set");
      checkOutput("ack_vs_set.irq", {7'd0, irqOut}, {7'd0, IRQ_EN});

      applyStimulus(1'b0, 8'h00, 1'b1, "ack2");
      applyStimulus(1'b1, 8'h80, 1'b0, "wr80");
      checkOutput("wr80.forced_q", {7'd0, quarterTick}, 8'd1);
      checkOutput("wr80.forced_h", {7'd0, halfTick}, 8'd1);
      runIdle(20, "seq5");
      checkOutput("seq5.irq_end", {7'd0, irqOut}, 8'd0);
      checkOutput("seq5.step_end", {5'd0, stepOut}, 8'd0);

      applyStimulus(1'b1, 8'h00, 1'b0, "wr4");
      runIdle(3, "pre_tc");
      applyStimulus(1'b1, 8'h00, 1'b0, "wr_tc");
      checkOutput("wr_tc.no_quarter", {7'd0, quarterTick}, 8'd0);
      checkOutput("wr_tc.no_half", {7'd0, halfTick}, 8'd0);
      runIdle(4, "post_tc");
      checkOutput("post_tc.quarter", {7'd0, quarterTick}, 8'd1);
      checkOutput("post_tc.step", {5'd0, stepOut}, 8'd1);

      $display("test done: total=%0d bad=%0d", nChecks, nBad);
      $finish;
   end

endmodule
